apb2reg_native_if: RTL and testbench

//  APB3 slave to reg_native_if bridge on native_clk; sits directly upstream of the native-to-memory bridge.

---
 rtl/apb2reg_native_if.sv | 96 +++++++++
 tb/tb_apb2reg_native_if.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/apb2reg_native_if.sv
// apb2reg_native_if: APB3 slave (psel/penable/pwrite/paddr/pwdata -> pready/prdata/pslverr) to native request/ack port (req_vld/addr/wr_en/rd_en/wr_data -> ack_vld/err/rd_data) with a watchdog that ends stalled transfers with pslverr
module apb2reg_native_if #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  native_clk,
  input  logic                  native_rst_n,
  input  logic                  soft_rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  req_vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack_vld,
  input  logic                  err,
  input  logic [DATA_WIDTH-1:0] rd_data
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state;
  logic pwrite_q;
  logic [CW-1:0] cnt;
  logic timeout;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge native_clk or negedge native_rst_n)
    if (!native_rst_n) begin
      state    <= IDLE;
      pwrite_q <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      wr_data  <= '0;
      req_vld  <= 1'b0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else if (soft_rst) begin
      state    <= IDLE;
      pwrite_q <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      wr_data  <= '0;
      req_vld  <= 1'b0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else begin
      req_vld <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      case (state)
        IDLE:
          if (psel && !penable) begin
            state    <= REQ;
            addr     <= paddr;
            wr_data  <= pwdata;
            pwrite_q <= pwrite;
            req_vld  <= 1'b1;
            wr_en    <= pwrite;
            rd_en    <= !pwrite;
          end
        REQ, WAIT:
          if (ack_vld) begin
            state   <= RESP;
            cnt     <= '0;
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= pwrite_q ? '0 : rd_data;
          end else if (state == WAIT && timeout) begin
            state   <= RESP;
            cnt     <= '0;
            pready  <= 1'b1;
            pslverr <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= state == WAIT ? cnt + 1'b1 : '0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb2reg_native_if.sv
// tb_apb2reg_native_if: cycle-scheduled transaction model checking the APB-to-native bridge every cycle
module tb_apb2reg_native_if;
  logic native_clk = 1'b0;
  logic native_rst_n = 1'b0;
  logic soft_rst = 1'b0;
  logic psel = 1'b0;
  logic penable = 1'b0;
  logic pwrite = 1'b0;
  logic [63:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic pready;
  logic [31:0] prdata;
  logic pslverr;
  logic req_vld;
  logic [63:0] addr;
  logic wr_en;
  logic rd_en;
  logic [31:0] wr_data;
  logic ack_vld = 1'b0;
  logic err = 1'b0;
  logic [31:0] rd_data = '0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int nreq = 0;
  bit exp_req[int];
  logic [63:0] exp_addr[int];
  logic [31:0] exp_wd[int];
  logic [32:0] exp_rsp[int];
  bit cr, cw, cp;
  logic [32:0] cv;
  apb2reg_native_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .native_clk(native_clk), .native_rst_n(native_rst_n), .soft_rst(soft_rst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .req_vld(req_vld), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
    .ack_vld(ack_vld), .err(err), .rd_data(rd_data)
  );
  always #5 native_clk = ~native_clk;
  always @(posedge native_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge native_clk) begin
    cr = exp_req.exists(cyc);
    cw = cr ? exp_req[cyc] : 1'b0;
    cp = exp_rsp.exists(cyc);
    cv = cp ? exp_rsp[cyc] : 33'h0;
    chk("req_vld", {63'h0, req_vld}, {63'h0, cr});
    chk("wr_en", {63'h0, wr_en}, {63'h0, cr & cw});
    chk("rd_en", {63'h0, rd_en}, {63'h0, cr & ~cw});
    if (cr) begin
      chk("addr", addr, exp_addr[cyc]);
      chk("wr_data", {32'h0, wr_data}, {32'h0, exp_wd[cyc]});
    end
    chk("pready", {63'h0, pready}, {63'h0, cp});
    chk("prdata", {32'h0, prdata}, {32'h0, cv[31:0]});
    chk("pslverr", {63'h0, pslverr}, {63'h0, cv[32]});
    if (req_vld) nreq++;
  end
  task automatic step();
    @(posedge native_clk);
    #1;
  endtask
  // d < 0 means the native side never acks, so the watchdog must end the transfer
  task automatic do_xfer(input bit w, input logic [63:0] a, input logic [31:0] wd,
                         input int d, input bit e, input logic [31:0] rd);
    int p, r;
    step();
    p = cyc;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
    exp_req[p+1] = w; exp_addr[p+1] = a; exp_wd[p+1] = wd;
    r = (d < 0) ? p + 10 : p + 2 + d;
    exp_rsp[r] = (d < 0) ? {1'b1, 32'h0} : {e, w ? 32'h0 : rd};
    step();
    penable = 1'b1;
    if (d >= 0) begin
      repeat (d) step();
      ack_vld = 1'b1; err = e; rd_data = rd;
      step();
      ack_vld = 1'b0; err = 1'b0; rd_data = '0;
    end
    while (cyc < r) step();
  endtask
  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) step();
  endtask
  initial begin
    int p;
    repeat (3) step();
    chk("rst_pready", {63'h0, pready}, 64'h0);
    chk("rst_addr", addr, 64'h0);
    native_rst_n = 1'b1;
    idle(2);
    do_xfer(1'b1, 64'h40, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    chk("t1_pready", {63'h0, pready}, 64'h1);
    chk("t1_pslverr", {63'h0, pslverr}, 64'h0);
    idle(2);
    do_xfer(1'b0, 64'h44, 32'h0, 0, 1'b0, 32'h12345678);
    chk("t2_prdata", {32'h0, prdata}, 64'h12345678);
    chk("t2_pready", {63'h0, pready}, 64'h1);
    idle(1);
    do_xfer(1'b0, 64'h48, 32'h0, 1, 1'b1, 32'hCAFEF00D);
    chk("t3r_pslverr", {63'h0, pslverr}, 64'h1);
    chk("t3r_prdata", {32'h0, prdata}, 64'hCAFEF00D);
    do_xfer(1'b1, 64'h4C, 32'h11112222, 2, 1'b1, 32'h99999999);
    chk("t3w_pslverr", {63'h0, pslverr}, 64'h1);
    chk("t3w_prdata", {32'h0, prdata}, 64'h0);
    idle(1);
    do_xfer(1'b0, 64'h100, 32'h0, -1, 1'b0, 32'h0);
    chk("t4_pslverr", {63'h0, pslverr}, 64'h1);
    chk("t4_prdata", {32'h0, prdata}, 64'h0);
    idle(4);
    ack_vld = 1'b1; err = 1'b1; rd_data = 32'hBADBAD00;
    step();
    ack_vld = 1'b0; err = 1'b0; rd_data = '0;
    idle(2);
    do_xfer(1'b0, 64'h104, 32'h0, 2, 1'b0, 32'h0BADCAFE);
    chk("t4_next_prdata", {32'h0, prdata}, 64'h0BADCAFE);
    idle(1);
    step();
    p = cyc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 64'h80; pwdata = 32'h55AA55AA;
    exp_req[p+1] = 1'b1; exp_addr[p+1] = 64'h80; exp_wd[p+1] = 32'h55AA55AA;
    step();
    penable = 1'b1;
    step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    chk("t5_addr", addr, 64'h0);
    chk("t5_wr_data", {32'h0, wr_data}, 64'h0);
    idle(1);
    ack_vld = 1'b1; err = 1'b1; rd_data = 32'h77777777;
    step();
    ack_vld = 1'b0; err = 1'b0; rd_data = '0;
    idle(2);
    do_xfer(1'b1, 64'h84, 32'h13572468, 1, 1'b0, 32'h0);
    chk("t5_next_pslverr", {63'h0, pslverr}, 64'h0);
    idle(1);
    for (int i = 0; i < 4; i++)
      do_xfer(i % 2 == 0, 64'h1000 + 64'(8 * i), 32'hA0000000 + 32'(i),
              int'($urandom_range(0, 5)), 1'b0, 32'hC0000000 + 32'(i));
    idle(4);
    chk("req_count", 64'(nreq), 64'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "time limit");
  end
endmodule
